m_pkt_tx: RTL

M_PKT_TX -- requirements
Module: m_pkt_tx

---
 rtl/m_pkt_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/m_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : m_pkt_tx
// Function : Packet transmitter. Accepts a length descriptor, then streams
//            ceil(length/DATA_B) payload words as registered beats with
//            sop/eop flags, zeroes unused tail bytes on the eop beat, and
//            enforces an IPG-cycle idle gap after every packet.
// Revision : 1.0 - initial release
// ============================================================================
module m_pkt_tx #(
  parameter int DATA_B = 16,
  parameter int LEN_W  = 16,
  parameter int IPG    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [LEN_W-1:0]      cmd_length,
  input  logic                  pld_vld,
  output logic                  pld_rdy,
  input  logic [DATA_B*8-1:0]   pld_data,
  output logic                  out_vld_r,
  output logic                  out_sop_r,
  output logic                  out_eop_r,
  output logic [LEN_W-1:0]      out_length_r,
  output logic [DATA_B*8-1:0]   out_data_r,
  output logic                  err_zero_len_r,
  output logic [31:0]           pkt_cnt_r
);

  localparam int                c_gap_w      = (IPG > 1) ? $clog2(IPG) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'((IPG > 0) ? IPG - 1 : 0);
  localparam logic [LEN_W:0]    c_beat_add   = (LEN_W+1)'(DATA_B - 1);
  localparam logic [LEN_W:0]    c_beat_div   = (LEN_W+1)'(DATA_B);
  localparam logic [LEN_W:0]    c_one_beat   = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0]  c_data_b_len = LEN_W'(DATA_B);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W:0]       r_beats_rem;
  logic                 r_first;
  logic [c_gap_w-1:0]   r_gap_cnt;

  logic [LEN_W:0]       w_beats;
  logic [LEN_W-1:0]     w_rem;
  logic                 w_last;
  logic [DATA_B-1:0]    w_keep;
  logic [DATA_B*8-1:0]  w_mask_data;

  // Handshake readiness follows the state; cmd_rdy is also held low while in reset
  assign cmd_rdy = (r_state == ST_IDLE) && !rst;
  assign pld_rdy = (r_state == ST_SEND);

  // Beat count is computed one bit wider than the length so a near-max length cannot wrap
  assign w_beats = ({1'b0, cmd_length} + c_beat_add) / c_beat_div;
  assign w_rem   = r_len % c_data_b_len;
  assign w_last  = (r_beats_rem == c_one_beat);

  // Tail-byte mask for the eop beat; a remainder of zero means the last word is full
  for (genvar gi = 0; gi < DATA_B; gi++) begin : g_byte
    localparam logic [LEN_W-1:0] c_idx = LEN_W'(gi);
    assign w_keep[gi] = (w_rem == '0) || (c_idx < w_rem);
    assign w_mask_data[gi*8 +: 8] = w_keep[gi] ? pld_data[gi*8 +: 8] : 8'h00;
  end

  // Control FSM plus registered beat outputs; outputs default to zero each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_beats_rem    <= '0;
      r_first        <= 1'b0;
      r_gap_cnt      <= '0;
      out_vld_r      <= 1'b0;
      out_sop_r      <= 1'b0;
      out_eop_r      <= 1'b0;
      out_length_r   <= '0;
      out_data_r     <= '0;
      err_zero_len_r <= 1'b0;
      pkt_cnt_r      <= '0;
    end else begin
      out_vld_r      <= 1'b0;
      out_sop_r      <= 1'b0;
      out_eop_r      <= 1'b0;
      out_length_r   <= '0;
      out_data_r     <= '0;
      err_zero_len_r <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_vld) begin
            if (cmd_length == '0) begin
              err_zero_len_r <= 1'b1;
            end else begin
              r_len       <= cmd_length;
              r_beats_rem <= w_beats;
              r_first     <= 1'b1;
              r_state     <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (pld_vld) begin
            out_vld_r    <= 1'b1;
            out_sop_r    <= r_first;
            out_eop_r    <= w_last;
            out_length_r <= r_len;
            out_data_r   <= w_last ? w_mask_data : pld_data;
            r_first      <= 1'b0;
            r_beats_rem  <= r_beats_rem - c_one_beat;
            if (w_last) begin
              pkt_cnt_r <= pkt_cnt_r + 32'd1;
              r_gap_cnt <= '0;
              r_state   <= (IPG == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
